matrix_unpack_16: RTL and testbench
===================================

# matrix_unpack_16

Sequential unpacker on the consumer side of the 16-lane, 16-bit matrix adder. It accepts one 256-bit packed result vector (16 elements of 16 bits) through a valid/ready handshake. It then emits the elements one per cycle on a 16-bit streaming port, most-significant lane first. This lets narrow downstream logic (memory writer, UART/debug tap) read adder results without a 256-bit datapath.

## Interface
- `LANES`, default 16: elements per packed vector; fixed at 16 for this release.
- `W`, default 16: element width in bits; packed width = `LANES*W` = 256.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_data`  input  256  packed vector; element 0 = `in_data[255:240]`, element 15 = `in_data[15:0]`.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  block can accept a vector this cycle.
- `out_data`  output  16  current element.
- `out_index`  output  4  lane number of `out_data` (0..15).
- `out_last`  output  1  high when `out_index == 15`.
- `out_valid`  output  1  `out_data` is valid.
- `out_ready`  input  1  downstream accepts the element.
- `busy`  output  1  high while a vector is being streamed (mirrors `out_valid`).

## Operation
- Storage: one 256-bit holding register `buf`, a 4-bit element counter `idx`, and a state register with states IDLE and STREAM.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid`, capture `buf <= in_data`, set `idx <= 0`, go to STREAM.
- STREAM:
  - `out_valid`=1.
  - `out_data = buf[255-16*idx -: 16]`, `out_index = idx`.
  - An element transfers on `out_valid && out_ready`.
  - A transfer with `idx != 15` increments `idx`.
  - A transfer with `idx == 15` ends the vector.
- End of vector:
  - If `in_valid` is high in the same cycle, capture the new vector, reset `idx` to 0 and stay in STREAM (back-to-back, no bubble).
  - Otherwise go to IDLE.
- `in_ready` in STREAM = `out_ready && idx == 15`, i.e. a combinational path from `out_ready`. This is the only combinational input-to-output path.
- Stall: while `out_ready`=0, `out_data`, `out_index` and `out_last` hold stable. `out_valid` never drops once asserted until the last element transfers.
- `in_valid` while not ready: ignored, no capture. The upstream must hold the data.
- Data is passed through unmodified; no arithmetic or width change. Element value 0xFFFF streams as-is.
- Reset (any cycle, including mid-vector): state returns to IDLE, `idx`=0, `buf`=0. Partially streamed vectors are discarded; no partial last is emitted.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_index`=0, `out_last`=0, `busy`=0.
- Latency: a vector captured at edge N presents element 0 at cycle N+1, registered.
- Throughput: with `out_ready` held at 1, exactly 16 cycles per vector. Continuous `in_valid` gives 100% output occupancy.
- `out_data` is muxed from registered `buf` and `idx`; no combinational path from `in_data`.
- Reset deassertion is synchronized externally; the block only requires `rst` to be asynchronous on assertion.

## Structure
- Shared package `matrix_pkg`:
  - `LANES`=16 and `W`=16 constants.
  - Packed width `VEC_W`=256.
  - A state enum type {IDLE, STREAM} for reuse by the future packer/serializer pair.
- Sub-module `lane_sel` is natural: a purely combinational 256-to-16 lane mux (index to slice, MSB-first), reusable by the matching packer.

## Test plan
- Single vector, `out_ready`=1: `in_data` = {16'h0001, 16'h0002, …, 16'h0010} -> outputs 0x0001..0x0010 on 16 consecutive cycles starting the cycle after capture. `out_index` runs 0..15 and `out_last` is high only with 0x0010. Then `in_ready` returns to 1.
- Back-to-back: vector A (all 16'hAAAA), then vector B (all 16'h5555) presented at A's last transfer -> 32 consecutive valid cycles, no bubble. B is captured in the cycle `out_last` transfers.
- Backpressure: toggle `out_ready` 1-0-0-1 pseudo-randomly -> every element appears exactly once in order and holds stable while stalled. `in_ready`=0 throughout STREAM except at the last-element transfer.
- Ignored input: assert `in_valid` with 16'hDEAD… mid-stream (`idx`=5) -> no capture; the current vector completes unchanged.
- Reset mid-operation: assert `rst` at `idx`=7 -> the same cycle shows `out_valid`=0, `in_ready`=1, `out_index`=0. After release, the next vector starts at element 0.
- Edge data: vector of all 16'hFFFF, then all 16'h0000 -> exact passthrough, 32 elements, checked against a scoreboard.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants and FSM state type for the matrix adder's packer/unpacker pair.
package matrix_pkg;
  localparam int LANES = 16;
  localparam int W     = 16;
  localparam int VEC_W = LANES * W;

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;
endpackage

// File: rtl/matrix_unpack_16_lane_sel.sv
// Combinational lane mux: picks element sel_i of a packed vector, element 0 in the MSBs.
module lane_sel #(
  parameter int LANES = 16,
  parameter int W     = 16
) (
  input  logic [LANES*W-1:0]         vec_i,
  input  logic [$clog2(LANES)-1:0]   sel_i,
  output logic [W-1:0]               lane_o
);
  always_comb begin
    lane_o = vec_i[(LANES - 1 - int'(sel_i)) * W +: W];
  end
endmodule

// File: rtl/matrix_unpack_16.sv
// Unpacks one 256-bit result vector into 16 sequential 16-bit elements, MSB lane first.
module matrix_unpack_16
  import matrix_pkg::*;
#(
  parameter int LANES = 16,
  parameter int W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LANES*W-1:0]         in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [W-1:0]               out_data,
  output logic [$clog2(LANES)-1:0]   out_index,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy
);
  localparam int IW = $clog2(LANES);
  localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

  state_e               state_q, state_d;
  logic [LANES*W-1:0]   buf_q, buf_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 at_last;

  assign at_last = (idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
    end
  end

  // A new vector may load either from IDLE or on the final transfer, so streams run back-to-back.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    if (in_valid && in_ready) begin
      buf_d   = in_data;
      idx_d   = '0;
      state_d = STREAM;
    end else if (state_q == STREAM && out_ready) begin
      if (at_last) begin
        idx_d   = '0;
        state_d = IDLE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    out_last  = 1'b0;
    if (state_q == STREAM) begin
      in_ready  = out_ready && at_last;
      out_valid = 1'b1;
      out_last  = at_last;
    end
    busy      = out_valid;
    out_index = idx_q;
  end

  lane_sel #(
    .LANES (LANES),
    .W     (W)
  ) u_lane_sel (
    .vec_i  (buf_q),
    .sel_i  (idx_q),
    .lane_o (out_data)
  );
endmodule

// File: tb/tb_matrix_unpack_16.sv
// Scoreboard bench for matrix_unpack_16: captured vectors expand into expected element queues.
module tb_matrix_unpack_16;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [15:0]  out_data;
  logic [3:0]   out_index;
  logic         out_last;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         busy;

  int checks = 0;
  int failures = 0;
  bit bp_mode = 1'b0;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  index;
    logic        last;
  } elem_t;

  elem_t exp_q[$];

  matrix_unpack_16 #(.LANES(16), .W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a captured vector is simply its 16 slices in order, element 0 = top 16 bits.
  task automatic push_vector(input logic [255:0] v);
    elem_t e;
    for (int k = 0; k < 16; k++) begin
      e.data  = v[255 - 16*k -: 16];
      e.index = 4'(k);
      e.last  = (k == 15);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: samples on the falling edge, between driver updates and the active edge.
  elem_t held;
  bit    stall_hold = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_hold = 1'b0;
    end else begin
      elem_t e;
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("busy", 32'(busy), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready),
          32'((exp_q.size() == 0) || (out_ready && exp_q.size() == 1)));
      if (stall_hold) begin
        chk("stall_data", 32'(out_data), 32'(held.data));
        chk("stall_index", 32'(out_index), 32'(held.index));
        chk("stall_last", 32'(out_last), 32'(held.last));
      end
      if (out_valid && out_ready) begin
        stall_hold = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got data 0x%0h with empty scoreboard", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_index", 32'(out_index), 32'(e.index));
          chk("out_last", 32'(out_last), 32'(e.last));
        end
      end else if (out_valid) begin
        held.data  = out_data;
        held.index = out_index;
        held.last  = out_last;
        stall_hold = 1'b1;
      end else begin
        stall_hold = 1'b0;
      end
      if (in_valid && in_ready) push_vector(in_data);
    end
  end

  always @(posedge clk) begin
    #1;
    out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send_vec(input logic [255:0] v);
    bit got = 1'b0;
    in_data  = v;
    in_valid = 1'b1;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 expected capture within 400 cycles");
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(posedge clk);
      #1;
      done = (exp_q.size() == 0) && !out_valid;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic wait_index(input logic [3:0] target);
    bit hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(posedge clk);
      #1;
      hit = out_valid && (out_index == target);
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL wait_index: got index %0d expected %0d", out_index, target);
    end
  endtask

  function automatic logic [255:0] fill(input logic [15:0] x);
    logic [255:0] v;
    for (int k = 0; k < 16; k++) v[16*k +: 16] = x;
    return v;
  endfunction

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [255:0] v;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Incrementing vector 0x0001..0x0010
    for (int k = 0; k < 16; k++) v[255 - 16*k -: 16] = 16'(k + 1);
    send_vec(v);
    drain();

    // Back-to-back pair, then edge values
    send_vec(fill(16'hAAAA));
    send_vec(fill(16'h5555));
    drain();
    send_vec(fill(16'hFFFF));
    send_vec(fill(16'h0000));
    drain();

    // Ignored input while streaming
    send_vec(fill(16'h1234));
    wait_index(4'd5);
    chk("busy_in_ready", 32'(in_ready), 32'd0);
    in_data  = fill(16'hDEAD);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // Randomized data under backpressure, some back-to-back
    bp_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_vec(rand_vec());
      if ($urandom_range(0, 1) == 0) drain();
    end
    drain();
    bp_mode = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous reset mid-vector
    send_vec(rand_vec());
    wait_index(4'd7);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_index", 32'(out_index), 32'd0);
    chk("midrst_out_last", 32'(out_last), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    send_vec(rand_vec());
    chk("post_rst_index", 32'(out_index), 32'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end
endmodule
